commit_trace_buffer: RTL

//  Captures one retirement record per committed instruction from the RTL core: PC, rd writeback and store.

---
 rtl/commit_trace_pkg.sv | 48 ++++
 rtl/trace_fifo.sv | 78 +++++++
 rtl/commit_trace_buffer.sv | 106 ++++++++++
 3 files changed

// File: rtl/commit_trace_pkg.sv
// Shared types and helpers for the commit trace buffer.
// trace_rec_t is the record the scoreboard receives. write_op_e uses the same numeric codes as
// the ISS write_op field, so the two traces compare without translation.
package commit_trace_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned SEQ_W = 16;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    BYTE = 2'd1,
    HALF = 2'd2,
    WORD = 2'd3
  } write_op_e;

  typedef struct packed {
    logic [SEQ_W-1:0] seq;
    logic [XLEN-1:0]  pc;
    logic [4:0]       rd;
    logic [XLEN-1:0]  wdata;
    write_op_e        write_op;
    logic [XLEN-1:0]  waddr;
  } trace_rec_t;

  localparam int unsigned RecW = $bits(trace_rec_t);

  // Mask for right-aligned store data; size 3 is illegal and treated as a full word.
  function automatic logic [XLEN-1:0] size_mask(input logic [1:0] size);
    logic [XLEN-1:0] mask;
    unique case (size)
      2'd0:    mask = XLEN'(32'h0000_00FF);
      2'd1:    mask = XLEN'(32'h0000_FFFF);
      default: mask = '1;
    endcase
    return mask;
  endfunction

  function automatic write_op_e size_to_op(input logic [1:0] size);
    write_op_e op;
    unique case (size)
      2'd0:    op = BYTE;
      2'd1:    op = HALF;
      default: op = WORD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Generic synchronous show-ahead FIFO.
// The head entry is held in a register (dout_q) so that dout_o shows a newly pushed entry one
// edge after the push and keeps its last value while the FIFO is empty.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   push_i, pop_i     write / read strobes (caller guarantees no push when full unless popping,
//                     and no pop when empty)
//   din_i, dout_o     write data / head entry
//   full_o, empty_o   status flags
//   level_o           occupancy, 0..DEPTH
module trace_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      level_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      level_q, level_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [AW-1:0]    rptr_inc;

  assign rptr_inc = rptr_q + AW'(1);
  assign empty_o  = (level_q == '0);
  assign full_o   = (level_q == (AW + 1)'(DEPTH));
  assign level_o  = level_q;
  assign dout_o   = dout_q;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    dout_d  = dout_q;
    if (push_i) wptr_d = wptr_q + AW'(1);
    if (pop_i)  rptr_d = rptr_inc;
    if (push_i && !pop_i)      level_d = level_q + (AW + 1)'(1);
    else if (pop_i && !push_i) level_d = level_q - (AW + 1)'(1);
    // Refresh the head register with whatever becomes the oldest entry after this edge.
    if (empty_o && push_i) begin
      dout_d = din_i;
    end else if (pop_i && level_q > (AW + 1)'(1)) begin
      dout_d = mem_q[rptr_inc];
    end else if (pop_i && push_i) begin
      dout_d = din_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      dout_q  <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      dout_q  <= dout_d;
    end
  end

  // Storage needs no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q] <= din_i;
  end

endmodule

// File: rtl/commit_trace_buffer.sv
// Commit trace buffer: formats one retirement record per committed instruction and queues it
// in a show-ahead FIFO presented over valid/ready to the scoreboard.
// Optional feature macro: COMMIT_TRACE_STALL_EN (drives stall_o at level >= DEPTH-2; otherwise
// stall_o is tied 0). XLEN and SEQ_W come from commit_trace_pkg.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   ret_valid_i, ret_pc_i           retirement strobe and PC
//   rd_we_i, rd_addr_i, rd_wdata_i  rd writeback
//   st_valid_i, st_size_i,
//   st_addr_i, st_wdata_i           store (size 0=byte 1=half 2/3=word)
//   out_valid_o, out_ready_i,
//   out_rec_o                       head record (trace_rec_t), valid/ready
//   level_o                         occupancy
//   overflow_o                      sticky lost-record flag
//   stall_o                         back-pressure to the core
module commit_trace_buffer
  import commit_trace_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  localparam int unsigned LevelW = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ret_valid_i,
  input  logic [XLEN-1:0]   ret_pc_i,
  input  logic              rd_we_i,
  input  logic [4:0]        rd_addr_i,
  input  logic [XLEN-1:0]   rd_wdata_i,
  input  logic              st_valid_i,
  input  logic [1:0]        st_size_i,
  input  logic [XLEN-1:0]   st_addr_i,
  input  logic [XLEN-1:0]   st_wdata_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [RecW-1:0]   out_rec_o,
  output logic [LevelW-1:0] level_o,
  output logic              overflow_o,
  output logic              stall_o
);

  logic [SEQ_W-1:0] seq_q, seq_d;
  logic             overflow_q, overflow_d;
  trace_rec_t       rec;
  logic             full, empty, push, pop;

  always_comb begin
    rec       = '0;
    rec.seq   = seq_q;
    rec.pc    = ret_pc_i;
    rec.rd    = (rd_we_i && rd_addr_i != 5'd0) ? rd_addr_i : 5'd0;
    // A store owns wdata even when rd is also written; rd is still reported.
    if (st_valid_i) begin
      rec.wdata    = st_wdata_i & size_mask(st_size_i);
      rec.write_op = size_to_op(st_size_i);
      rec.waddr    = st_addr_i;
    end else if (rec.rd != 5'd0) begin
      rec.wdata = rd_wdata_i;
    end
  end

  assign out_valid_o = !empty;
  assign pop         = !empty && out_ready_i;
  // A pop in the same cycle frees the slot a full FIFO needs.
  assign push        = ret_valid_i && (!full || pop);

  always_comb begin
    seq_d      = seq_q;
    overflow_d = overflow_q;
    if (push) seq_d = seq_q + SEQ_W'(1);
    if (ret_valid_i && full && !pop) overflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seq_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      seq_q      <= seq_d;
      overflow_q <= overflow_d;
    end
  end

  assign overflow_o = overflow_q;

`ifdef COMMIT_TRACE_STALL_EN
  assign stall_o = (level_o >= LevelW'(DEPTH - 2));
`else
  assign stall_o = 1'b0;
`endif

  trace_fifo #(
    .WIDTH (RecW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (rec),
    .dout_o  (out_rec_o),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level_o)
  );

endmodule
